// File: rtl/lsu_byte_lane.sv
// Load/store unit: splits byte/half/word requests into four independently addressed byte lanes.
// Latency: store/error response one cycle after accept, load response two cycles after accept.
// Backpressure: accepts only in IDLE (req_ready); the response is an unstalled one-cycle pulse.
module lsu_byte_lane (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [9:0]  o_addr_0,
  output logic [9:0]  o_addr_1,
  output logic [9:0]  o_addr_2,
  output logic [9:0]  o_addr_3,
  output logic [7:0]  o_data_0,
  output logic [7:0]  o_data_1,
  output logic [7:0]  o_data_2,
  output logic [7:0]  o_data_3,
  output logic        o_we_0,
  output logic        o_we_1,
  output logic        o_we_2,
  output logic        o_we_3,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic        f3_legal;
  logic        req_err;
  logic [2:0]  size;

  logic [1:0]  lane_k    [4];
  logic [8:0]  lane_word [4];
  logic [3:0]  lane_use;
  logic [9:0]  lane_idx  [4];
  logic [3:0]  lane_we;
  logic [7:0]  lane_dat  [4];

  logic [9:0]  addr_q    [4];
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [7:0]  rd_byte   [4];
  logic [31:0] load_data;

  // Reset wins over a same-cycle request so nothing is written while reset is high.
  assign o_req_ready = (state_q == IDLE);
  assign accept      = i_req_valid && (state_q == IDLE) && !i_reset;

  // Decode access size and legality.
  always_comb begin
    f3_legal = 1'b0;
    size     = 3'd1;
    case (i_req_funct3)
      3'b000, 3'b100: begin f3_legal = 1'b1; size = 3'd1; end
      3'b001, 3'b101: begin f3_legal = 1'b1; size = 3'd2; end
      3'b010:         begin f3_legal = 1'b1; size = 3'd4; end
      default:        begin f3_legal = 1'b0; size = 3'd1; end
    endcase
    req_err = !f3_legal || (i_req_addr[31:11] != 21'd0);
  end

  // Per-lane byte number, word index and write strobe. A lane below the start
  // offset holds a byte that spilled into the next word (wrapping at 512 words).
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      lane_k[l]    = 2'(l) - i_req_addr[1:0];
      lane_use[l]  = ({1'b0, lane_k[l]} < size);
      lane_word[l] = lane_use[l]
                   ? i_req_addr[10:2] + {8'd0, (2'(l) < i_req_addr[1:0])}
                   : i_req_addr[10:2];
      lane_idx[l]  = {lane_word[l], (l >= 2)};
      lane_we[l]   = accept && i_req_we && !req_err && lane_use[l];
      lane_dat[l]  = lane_we[l] ? i_req_wdata[{lane_k[l], 3'b000} +: 8] : 8'd0;
    end
  end

  assign o_addr_0 = i_reset ? 10'd0 : (accept ? lane_idx[0] : addr_q[0]);
  assign o_addr_1 = i_reset ? 10'd0 : (accept ? lane_idx[1] : addr_q[1]);
  assign o_addr_2 = i_reset ? 10'd0 : (accept ? lane_idx[2] : addr_q[2]);
  assign o_addr_3 = i_reset ? 10'd0 : (accept ? lane_idx[3] : addr_q[3]);
  assign o_we_0   = lane_we[0];
  assign o_we_1   = lane_we[1];
  assign o_we_2   = lane_we[2];
  assign o_we_3   = lane_we[3];
  assign o_data_0 = lane_dat[0];
  assign o_data_1 = lane_dat[1];
  assign o_data_2 = lane_dat[2];
  assign o_data_3 = lane_dat[3];

  // Gather access bytes from their lanes, then sign/zero-extend by size.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_byte[k] = i_mem_rdata[{(off_q + 2'(k)), 3'b000} +: 8];
    end
    case (f3_q)
      3'b000:  load_data = {{24{rd_byte[0][7]}}, rd_byte[0]};
      3'b001:  load_data = {{16{rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
      3'b010:  load_data = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
      3'b100:  load_data = {24'd0, rd_byte[0]};
      3'b101:  load_data = {16'd0, rd_byte[1], rd_byte[0]};
      default: load_data = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: loads wait one cycle for the RAM; stores and errors respond directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (i_req_we || req_err) ? RESP : RD_WAIT;
      RD_WAIT: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture request context on accept and the extended load data in RD_WAIT.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int l = 0; l < 4; l++) addr_q[l] <= 10'd0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else if (accept) begin
      for (int l = 0; l < 4; l++) addr_q[l] <= lane_idx[l];
      f3_q    <= i_req_funct3;
      off_q   <= i_req_addr[1:0];
      err_q   <= req_err;
      rdata_q <= 32'd0;
    end else if (state_q == RD_WAIT) begin
      rdata_q <= load_data;
    end
  end

  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_err   = err_q && (state_q == RESP);
  assign o_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_byte_lane.sv
module tb_lsu_byte_lane;

  logic        i_clk;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [9:0]  o_addr_0, o_addr_1, o_addr_2, o_addr_3;
  logic [7:0]  o_data_0, o_data_1, o_data_2, o_data_3;
  logic        o_we_0, o_we_1, o_we_2, o_we_3;
  logic [31:0] i_mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  lsu_byte_lane dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_addr_0(o_addr_0), .o_addr_1(o_addr_1), .o_addr_2(o_addr_2), .o_addr_3(o_addr_3),
    .o_data_0(o_data_0), .o_data_1(o_data_1), .o_data_2(o_data_2), .o_data_3(o_data_3),
    .o_we_0(o_we_0), .o_we_1(o_we_1), .o_we_2(o_we_2), .o_we_3(o_we_3),
    .i_mem_rdata(i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Two dual-port byte RAMs: A serves lanes 0/2, B serves lanes 1/3; registered read.
  logic [7:0] ram_a [1024] = '{default: 8'h00};
  logic [7:0] ram_b [1024] = '{default: 8'h00};

  always @(posedge i_clk) begin
    if (o_we_0) ram_a[o_addr_0] <= o_data_0;
    if (o_we_2) ram_a[o_addr_2] <= o_data_2;
    if (o_we_1) ram_b[o_addr_1] <= o_data_1;
    if (o_we_3) ram_b[o_addr_3] <= o_data_3;
    i_mem_rdata <= {ram_b[o_addr_3], ram_a[o_addr_2], ram_b[o_addr_1], ram_a[o_addr_0]};
  end

  wire [3:0]  we_v   = {o_we_3, o_we_2, o_we_1, o_we_0};
  wire [39:0] addr_v = {o_addr_3, o_addr_2, o_addr_1, o_addr_0};
  wire [31:0] dat_v  = {o_data_3, o_data_2, o_data_1, o_data_0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present a request at the falling edge; outputs are settled 1 time unit later.
  task automatic start(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge i_clk);
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = a;
    i_req_wdata  = wd;
    #1;
    chk({tag, "_ready"}, {63'd0, o_req_ready}, 64'd1);
  endtask

  // Drop valid, wait (bounded) for the response pulse and check it.
  task automatic finish_rsp(input string tag, input int lat,
                            input logic [31:0] rd, input logic err);
    int n;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    n = 1;
    chk({tag, "_we_after"}, {60'd0, we_v}, 64'd0);
    while (!o_rsp_valid && n < 6) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_rdata"}, {32'd0, o_rsp_rdata}, {32'd0, rd});
    chk({tag, "_err"}, {63'd0, o_rsp_err}, {63'd0, err});
    @(negedge i_clk);
    chk({tag, "_pulse"}, {63'd0, o_rsp_valid}, 64'd0);
    chk({tag, "_ready_back"}, {63'd0, o_req_ready}, 64'd1);
  endtask

  logic [5:0] pat;
  int         seen;

  initial begin
    i_reset = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0;
    i_req_funct3 = 3'd0; i_req_addr = 32'd0; i_req_wdata = 32'd0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    chk("rst_ready", {63'd0, o_req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
    chk("rst_rdata", {32'd0, o_rsp_rdata}, 64'd0);
    chk("rst_err", {63'd0, o_rsp_err}, 64'd0);
    chk("rst_we", {60'd0, we_v}, 64'd0);
    chk("rst_addr", {24'd0, addr_v}, 64'd0);
    chk("rst_data", {32'd0, dat_v}, 64'd0);

    // Aligned word store then load.
    start("sw8", 1'b1, 3'b010, 32'h008, 32'hDEADBEEF);
    chk("sw8_we", {60'd0, we_v}, 64'hF);
    chk("sw8_addr", {24'd0, addr_v}, {24'd0, 10'd5, 10'd5, 10'd4, 10'd4});
    chk("sw8_data", {32'd0, dat_v}, 64'hDEADBEEF);
    finish_rsp("sw8", 1, 32'd0, 1'b0);
    start("lw8", 1'b0, 3'b010, 32'h008, 32'd0);
    chk("lw8_we", {60'd0, we_v}, 64'd0);
    chk("lw8_addr", {24'd0, addr_v}, {24'd0, 10'd5, 10'd5, 10'd4, 10'd4});
    finish_rsp("lw8", 2, 32'hDEADBEEF, 1'b0);

    // Misaligned word load spanning words 1 and 2.
    start("sw4", 1'b1, 3'b010, 32'h004, 32'h11223344);
    finish_rsp("sw4", 1, 32'd0, 1'b0);
    start("sw8b", 1'b1, 3'b010, 32'h008, 32'h55667788);
    finish_rsp("sw8b", 1, 32'd0, 1'b0);
    start("lw6", 1'b0, 3'b010, 32'h006, 32'd0);
    chk("lw6_addr", {24'd0, addr_v}, {24'd0, 10'd3, 10'd3, 10'd4, 10'd4});
    finish_rsp("lw6", 2, 32'h77881122, 1'b0);

    // Byte store to lane 3, signed and unsigned byte loads.
    start("sb3", 1'b1, 3'b000, 32'h003, 32'h000000FF);
    chk("sb3_we", {60'd0, we_v}, 64'h8);
    chk("sb3_data", {32'd0, dat_v}, 64'hFF000000);
    chk("sb3_addr", {24'd0, addr_v}, {24'd0, 10'd1, 10'd1, 10'd0, 10'd0});
    finish_rsp("sb3", 1, 32'd0, 1'b0);
    start("lb3", 1'b0, 3'b000, 32'h003, 32'd0);
    finish_rsp("lb3", 2, 32'hFFFFFFFF, 1'b0);
    start("lbu3", 1'b0, 3'b100, 32'h003, 32'd0);
    finish_rsp("lbu3", 2, 32'h000000FF, 1'b0);

    // Half store wrapping from 0x7FF to 0x000.
    start("sh7ff", 1'b1, 3'b001, 32'h7FF, 32'h0000A5B6);
    chk("sh7ff_we", {60'd0, we_v}, 64'h9);
    chk("sh7ff_data", {32'd0, dat_v}, 64'hB60000A5);
    chk("sh7ff_addr", {24'd0, addr_v}, {24'd0, 10'd1023, 10'd1023, 10'd1022, 10'd0});
    finish_rsp("sh7ff", 1, 32'd0, 1'b0);
    start("lhu7ff", 1'b0, 3'b101, 32'h7FF, 32'd0);
    finish_rsp("lhu7ff", 2, 32'h0000A5B6, 1'b0);
    start("lh7ff", 1'b0, 3'b001, 32'h7FF, 32'd0);
    finish_rsp("lh7ff", 2, 32'hFFFFA5B6, 1'b0);

    // Error requests: out-of-range address, illegal funct3, blocked store.
    start("lw800", 1'b0, 3'b010, 32'h800, 32'd0);
    chk("lw800_we", {60'd0, we_v}, 64'd0);
    finish_rsp("lw800", 1, 32'd0, 1'b1);
    start("f3_011", 1'b0, 3'b011, 32'h008, 32'd0);
    chk("f3_011_we", {60'd0, we_v}, 64'd0);
    finish_rsp("f3_011", 1, 32'd0, 1'b1);
    start("sw800", 1'b1, 3'b010, 32'h800, 32'h12345678);
    chk("sw800_we", {60'd0, we_v}, 64'd0);
    finish_rsp("sw800", 1, 32'd0, 1'b1);
    start("lw0", 1'b0, 3'b010, 32'h000, 32'd0);
    finish_rsp("lw0", 2, 32'hFF0000A5, 1'b0);

    // Store presented while reset is high must not write.
    @(negedge i_clk);
    i_reset = 1'b1; i_req_valid = 1'b1; i_req_we = 1'b1;
    i_req_funct3 = 3'b010; i_req_addr = 32'h00C; i_req_wdata = 32'hCAFEF00D;
    #1;
    chk("rst_store_we", {60'd0, we_v}, 64'd0);
    @(negedge i_clk);
    i_reset = 1'b0; i_req_valid = 1'b0;
    start("lwc", 1'b0, 3'b010, 32'h00C, 32'd0);
    finish_rsp("lwc", 2, 32'd0, 1'b0);

    // Reset during RD_WAIT drops the response.
    start("lw_rst", 1'b0, 3'b010, 32'h008, 32'd0);
    @(negedge i_clk);
    i_req_valid = 1'b0; i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, o_req_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_rsp_valid) seen++;
      @(negedge i_clk);
    end
    chk("midrst_no_rsp", 64'(seen), 64'd0);

    // Back-to-back stores held valid: accept every 2 cycles.
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = 3'b010;
    i_req_addr = 32'h010; i_req_wdata = 32'h01020304;
    for (int i = 0; i < 6; i++) begin
      #1;
      pat[i] = o_req_ready;
      @(negedge i_clk);
    end
    i_req_valid = 1'b0;
    chk("stream_sw", {58'd0, pat}, 64'b010101);
    @(negedge i_clk);

    // Back-to-back loads held valid: accept every 3 cycles.
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_funct3 = 3'b010;
    i_req_addr = 32'h010;
    for (int i = 0; i < 6; i++) begin
      #1;
      pat[i] = o_req_ready;
      @(negedge i_clk);
    end
    i_req_valid = 1'b0;
    chk("stream_lw", {58'd0, pat}, 64'b001001);
    repeat (3) @(negedge i_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
